// File: rtl/wb_pkg.sv
// Shared types for the store write buffer.
// Entry layout and lane constants.
package wb_pkg;

    localparam int WB_DEPTH = 4;
    localparam int NLANE    = 4;

    typedef struct packed {
        logic        valid;
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  be;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_merge.sv
// Per-lane forwarding of pending store bytes.
// Youngest matching entry wins each lane.
module wb_fwd_merge
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0] i_ent,
    input  logic [PW-1:0]         i_head,
    input  logic [PW:0]           i_count,
    input  logic [29:0]           i_lk_word,
    output logic [31:0]           o_lk_data,
    output logic [3:0]            o_lk_be
);

    logic [PW-1:0] w_idx;

    // Walk oldest to youngest so later matches overwrite earlier ones
    always_comb begin
        o_lk_data = '0;
        o_lk_be   = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + PW'(i);
            if (((PW+1)'(i) < i_count) &&
                i_ent[w_idx].valid &&
                (i_ent[w_idx].word == i_lk_word)) begin
                for (int l = 0; l < NLANE; l++) begin
                    if (i_ent[w_idx].be[l]) begin
                        o_lk_data[8*l +: 8] = i_ent[w_idx].data[8*l +: 8];
                        o_lk_be[l]          = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between write-through cache and data memory.
// Coalesces into the youngest entry and forwards bytes to refills.
module store_write_buffer
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_push,
    input  logic [31:0]     wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic [3:0]      wb_be,
    output logic            wb_full,
    output logic            wb_empty,
    input  logic [31:0]     lk_addr,
    output logic [XLEN-1:0] lk_data,
    output logic [3:0]      lk_be,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [XLEN-1:0] mem_wd,
    output logic [3:0]      mem_be,
    input  logic            mem_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] C_TWO  = (PW+1)'(2);

    wb_entry_t [DEPTH-1:0] r_ent;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [PW:0]           r_count;

    wb_entry_t     w_head_ent;
    logic [PW-1:0] w_young;
    logic          w_pop;
    logic          w_acc;
    logic          w_merge;
    logic          w_alloc;
    logic [31:0]   w_mrg_data;
    logic          w_unused;

    assign w_unused   = ^{wb_addr[1:0], lk_addr[1:0]};

    assign w_head_ent = r_ent[r_head];
    assign w_young    = r_tail - 1'b1;

    assign wb_full    = (r_count == C_FULL);
    assign wb_empty   = (r_count == '0);

    assign mem_we     = !wb_empty;
    assign mem_addr   = {w_head_ent.word, 2'b00};
    assign mem_wd     = w_head_ent.data;
    assign mem_be     = w_head_ent.be;

    assign w_pop      = mem_we && mem_ready;
    assign w_acc      = wb_push && (!wb_full || w_pop);
    assign w_merge    = w_acc && (r_count >= C_TWO) &&
                        (r_ent[w_young].word == wb_addr[31:2]);
    assign w_alloc    = w_acc && !w_merge;

    // Byte-merge of the incoming store over the youngest entry
    always_comb begin
        w_mrg_data = r_ent[w_young].data;
        for (int l = 0; l < NLANE; l++) begin
            if (wb_be[l]) begin
                w_mrg_data[8*l +: 8] = wb_data[8*l +: 8];
            end
        end
    end

    // FIFO pointers, occupancy and entry storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_ent[r_head].valid <= 1'b0;
                r_head              <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_ent[r_tail] <= '{valid: 1'b1,
                                   word:  wb_addr[31:2],
                                   data:  wb_data,
                                   be:    wb_be};
                r_tail        <= r_tail + 1'b1;
            end
            if (w_merge) begin
                r_ent[w_young].data <= w_mrg_data;
                r_ent[w_young].be   <= r_ent[w_young].be | wb_be;
            end
            if (w_alloc && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_alloc && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    wb_fwd_merge #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .i_ent     (r_ent),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_lk_word (lk_addr[31:2]),
        .o_lk_data (lk_data),
        .o_lk_be   (lk_be)
    );

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: queue model plus directed vectors.
// Outputs are compared against the model on every negative edge.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_push = 1'b0;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [3:0]  wb_be = '0;
    logic        wb_full;
    logic        wb_empty;
    logic [31:0] lk_addr = '0;
    logic [31:0] lk_data;
    logic [3:0]  lk_be;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;

    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    ent_t q[$];
    wr_t  wlog[$];

    store_write_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_push   (wb_push),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_be     (wb_be),
        .wb_full   (wb_full),
        .wb_empty  (wb_empty),
        .lk_addr   (lk_addr),
        .lk_data   (lk_data),
        .lk_be     (lk_be),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_be    (mem_be),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(logic [31:0] a, logic [31:0] d, logic [3:0] be);
        wb_push = 1'b1;
        wb_addr = a;
        wb_data = d;
        wb_be   = be;
        tick();
        wb_push = 1'b0;
    endtask

    // Model: ordered list of pending writes
    always @(posedge clk) begin
        bit pop, acc, mrg;
        if (rst) begin
            q.delete();
        end else begin
            pop = (q.size() > 0) && mem_ready;
            acc = wb_push && ((q.size() < DEPTH) || pop);
            mrg = acc && (q.size() >= 2) && (q[q.size()-1].w == wb_addr[31:2]);
            if (mrg) begin
                for (int l = 0; l < 4; l++) begin
                    if (wb_be[l]) begin
                        q[q.size()-1].d[8*l +: 8] = wb_data[8*l +: 8];
                    end
                end
                q[q.size()-1].be = q[q.size()-1].be | wb_be;
            end
            if (pop) void'(q.pop_front());
            if (acc && !mrg) q.push_back('{wb_addr[31:2], wb_data, wb_be});
        end
    end

    // Compare DUT outputs against the model and log completed writes
    always @(negedge clk) begin
        logic [31:0] ed;
        logic [3:0]  eb;
        if (chk_en) begin
            chk("wb_empty", 32'(wb_empty), 32'(q.size() == 0));
            chk("wb_full", 32'(wb_full), 32'(q.size() == DEPTH));
            chk("mem_we", 32'(mem_we), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("mem_addr", mem_addr, {q[0].w, 2'b00});
                chk("mem_wd", mem_wd, q[0].d);
                chk("mem_be", 32'(mem_be), 32'(q[0].be));
            end
            ed = '0;
            eb = '0;
            foreach (q[i]) begin
                if (q[i].w == lk_addr[31:2]) begin
                    for (int l = 0; l < 4; l++) begin
                        if (q[i].be[l]) begin
                            ed[8*l +: 8] = q[i].d[8*l +: 8];
                            eb[l] = 1'b1;
                        end
                    end
                end
            end
            chk("lk_data", lk_data, ed);
            chk("lk_be", 32'(lk_be), 32'(eb));
            if (!rst && mem_we && mem_ready) begin
                wlog.push_back('{mem_addr, mem_wd, mem_be});
            end
        end
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Reset state and single store held until accepted
        chk("rst_empty", 32'(wb_empty), 32'd1);
        chk("rst_full", 32'(wb_full), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_lkbe", 32'(lk_be), 32'd0);
        lk_addr = 32'h0000_0100;
        push1(32'h100, 32'hDEADBEEF, 4'hF);
        chk("t1_we", 32'(mem_we), 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_hold_wd", mem_wd, 32'hDEADBEEF);
            chk("t1_hold_addr", mem_addr, 32'h100);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("t1_empty", 32'(wb_empty), 32'd1);

        // Fill to capacity; fifth push is dropped
        wlog.delete();
        lk_addr = 32'h204;
        for (int i = 0; i < 5; i++) begin
            push1(32'h200 + 32'(4*i), 32'h200 + 32'(4*i), 4'hF);
            if (i == 3) chk("t2_full", 32'(wb_full), 32'd1);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        mem_ready = 1'b0;
        chk("t2_nwr", wlog.size(), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("t2_order", wlog[i].a, 32'h200 + 32'(4*i));
        end

        // Coalescing into the youngest entry
        wlog.delete();
        lk_addr = 32'h304;
        push1(32'h300, 32'h000000AA, 4'h1);
        push1(32'h304, 32'h11111111, 4'hF);
        push1(32'h304, 32'h0000BB00, 4'h2);
        chk("t3_lkdata", lk_data, 32'h1111BB11);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mem_ready = 1'b0;
        chk("t3_nwr", wlog.size(), 32'd2);
        if (wlog.size() == 2) begin
            chk("t3_a0", wlog[0].a, 32'h300);
            chk("t3_d0", wlog[0].d, 32'h000000AA);
            chk("t3_a1", wlog[1].a, 32'h304);
            chk("t3_d1", wlog[1].d, 32'h1111BB11);
            chk("t3_be1", 32'(wlog[1].be), 32'hF);
        end

        // Forwarding across two entries for the same word
        push1(32'h400, 32'h11223344, 4'hF);
        push1(32'h400, 32'h00AA0000, 4'h4);
        lk_addr = 32'h402;
        #1;
        chk("t4_lkbe", 32'(lk_be), 32'hF);
        chk("t4_lkdata", lk_data, 32'h11AA3344);
        lk_addr = 32'h500;
        #1;
        chk("t4_miss_be", 32'(lk_be), 32'h0);
        chk("t4_miss_data", lk_data, 32'h0);
        tick();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        mem_ready = 1'b0;

        // Push accepted at full when a pop happens the same cycle
        wlog.delete();
        lk_addr = 32'h600;
        for (int i = 0; i < 4; i++) push1(32'h700 + 32'(4*i), 32'h70 + 32'(i), 4'hF);
        chk("t5_full", 32'(wb_full), 32'd1);
        mem_ready = 1'b1;
        push1(32'h600, 32'h66666666, 4'hF);
        mem_ready = 1'b0;
        chk("t5_still_full", 32'(wb_full), 32'd1);
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        mem_ready = 1'b0;
        chk("t5_nwr", wlog.size(), 32'd5);
        if (wlog.size() == 5) begin
            chk("t5_first", wlog[0].a, 32'h700);
            chk("t5_last", wlog[4].a, 32'h600);
            chk("t5_last_d", wlog[4].d, 32'h66666666);
        end

        // Reset mid-drain drops all pending writes
        lk_addr = 32'h800;
        for (int i = 0; i < 3; i++) push1(32'h800 + 32'(4*i), 32'h8 + 32'(i), 4'hF);
        chk("t6_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_we_after", 32'(mem_we), 32'd0);
        chk("t6_empty", 32'(wb_empty), 32'd1);
        wlog.delete();
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        mem_ready = 1'b0;
        chk("t6_nwr", wlog.size(), 32'd0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
